mul_seq_ctrl: RTL and testbench

//  - Sequences the EX-stage multiply: when the ALU control code is MUL (3'b101), holds the pipeline and runs a WIDTH-step shift-add multiply.
//  - Returns the low WIDTH bits of the product (RISC-V MUL semantics). All other ALU codes pass through untouched.
//  - Sits beside the ALU in EX. Drives the pipeline stall and the EX result mux select.

---
 rtl/mul_seq_pkg.sv | 24 ++
 rtl/mul_seq_dp.sv | 45 ++++
 rtl/mul_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: ALU control codes
// (also used by ALU_Control and the ALU) and the sequencer state encoding.
package mul_seq_pkg;

  localparam logic [2:0] AND  = 3'b000;
  localparam logic [2:0] XOR  = 3'b001;
  localparam logic [2:0] SLL  = 3'b010;
  localparam logic [2:0] ADD  = 3'b011;
  localparam logic [2:0] SUB  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] ADDI = 3'b110;
  localparam logic [2:0] SRAI = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [2:0] code);
    return code == MUL;
  endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add multiply datapath: accumulator, shifted multiplicand and
// multiplier. One step adds mcand when the multiplier LSB is set, then shifts.
module mul_seq_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic [WIDTH-1:0] acc,
  output logic             mplier_zero
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // mplier_zero reports the multiplier as it will be after the current step,
  // so the controller can leave RUN on the step that empties it.
  assign mplier_zero = (mplier >> 1) == '0;

  // Operand/accumulator registers: clear wins over load, load over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= rs1_data;
      mplier <= rs2_data;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage multiply sequencer. Stalls the pipeline while a MUL runs a
// WIDTH-step shift-add and presents the low WIDTH product bits for one cycle.
// Optional MUL_EARLY_TERM_EN: leave RUN once the multiplier shifts to zero.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             last_step;
  logic             load, step, clear;
  logic [WIDTH-1:0] acc;
  logic             mplier_zero;

  // start is gated by reset so stall_o is 0 while reset is held, even with a
  // MUL sitting in EX.
  assign start = rst_i & valid_i & is_mul(ALUCtrl_i) & ~flush_i;

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt == CNT_W'(WIDTH - 1)) | mplier_zero;
`else
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

  mul_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .load       (load),
    .step       (step),
    .clear      (clear),
    .rs1_data   (rs1_data_i),
    .rs2_data   (rs2_data_i),
    .acc        (acc),
    .mplier_zero(mplier_zero)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Iteration counter: restarts on issue, advances once per RUN step.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     cnt <= '0;
    else if (load)  cnt <= '0;
    else if (step)  cnt <= cnt + CNT_W'(1);
  end

  // Next state, datapath controls, stall and result-valid.
  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    step           = 1'b0;
    clear          = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          stall_o   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (flush_i) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last_step) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (flush_i) clear = 1'b1;
        else         result_valid_o = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o   = (state != IDLE);
  assign result_o = result_valid_o ? acc : '0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (honours MUL_EARLY_TERM_EN).
module tb_mul_seq_ctrl;
  import mul_seq_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic             flush_i;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic             stall_o;
  logic             busy_o;
  logic [WIDTH-1:0] result_o;
  logic             result_valid_o;

  int checks = 0;
  int fails  = 0;

  mul_seq_ctrl #(
    .WIDTH(WIDTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ALUCtrl_i     (ALUCtrl_i),
    .flush_i       (flush_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .stall_o       (stall_o),
    .busy_o        (busy_o),
    .result_o      (result_o),
    .result_valid_o(result_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: low half of the full-width product.
  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // Reference: number of RUN cycles for a given multiplier.
  function automatic int ref_runs(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int hi;
    hi = 1;
    for (int i = 0; i < 32; i++) if (b[i]) hi = i + 1;
    return hi;
`else
    return 32;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a MUL (waits out a DONE cycle first if called while busy) and
  // follow it to its result. Returns the number of RUN cycles seen.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int runs);
    valid_i    = 1'b1;
    ALUCtrl_i  = MUL;
    flush_i    = 1'b0;
    rs1_data_i = a;
    rs2_data_i = b;
    if (busy_o) @(negedge clk_i);
    #1;
    chk("issue_stall", 32'(stall_o), 32'd1);
    chk("issue_busy",  32'(busy_o), 32'd0);
    chk("issue_rv",    32'(result_valid_o), 32'd0);
    runs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (result_valid_o) break;
      runs++;
      chk("run_stall",  32'(stall_o), 32'd1);
      chk("run_busy",   32'(busy_o), 32'd1);
      chk("run_result", result_o, 32'd0);
    end
    chk("run_cycles",  32'(runs), 32'(ref_runs(b)));
    chk("done_rv",     32'(result_valid_o), 32'd1);
    chk("done_result", result_o, ref_prod(a, b));
    chk("done_stall",  32'(stall_o), 32'd0);
    chk("done_busy",   32'(busy_o), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    valid_i = 1'b0;
    flush_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      #1;
      chk("idle_busy",  32'(busy_o), 32'd0);
      chk("idle_stall", 32'(stall_o), 32'd0);
      chk("idle_rv",    32'(result_valid_o), 32'd0);
    end
  endtask

  initial begin
    int runs;
    logic [31:0] a, b;

    // Reset, with a MUL already sitting in EX.
    rst_i = 1'b0; valid_i = 1'b1; ALUCtrl_i = MUL; flush_i = 1'b0;
    rs1_data_i = 32'd7; rs2_data_i = 32'd6;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_stall",  32'(stall_o), 32'd0);
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_rv",     32'(result_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    idle_cycles(1);

    // 7 * 6: 42, stall for issue + RUN cycles (33 in the fixed-latency build).
    do_mul(32'd7, 32'd6, runs);
`ifdef MUL_EARLY_TERM_EN
    chk("mul7x6_stall_cycles", 32'(runs + 1), 32'd4);
`else
    chk("mul7x6_stall_cycles", 32'(runs + 1), 32'd33);
`endif
    idle_cycles(1);

    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, runs);
    chk("mul_ones_literal", result_o, 32'h0000_0001);
    idle_cycles(1);
    do_mul(-32'sd3, 32'd5, runs);
    chk("mul_neg3x5_literal", result_o, 32'hFFFF_FFF1);
    idle_cycles(1);

    // Non-MUL codes, invalid MUL and flushed MUL never start.
    valid_i = 1'b1; ALUCtrl_i = ADD;
    rs1_data_i = $urandom; rs2_data_i = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); #1;
      chk("add_stall", 32'(stall_o), 32'd0);
      chk("add_busy",  32'(busy_o), 32'd0);
      chk("add_rv",    32'(result_valid_o), 32'd0);
    end
    valid_i = 1'b0; ALUCtrl_i = MUL;
    @(negedge clk_i); #1;
    chk("novalid_stall", 32'(stall_o), 32'd0);
    chk("novalid_busy",  32'(busy_o), 32'd0);
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i); #1;
    chk("flushed_stall", 32'(stall_o), 32'd0);
    chk("flushed_busy",  32'(busy_o), 32'd0);
    idle_cycles(1);

    // Flush at RUN cycle 10, then 2 * 3.
    valid_i = 1'b1; ALUCtrl_i = MUL; flush_i = 1'b0;
    rs1_data_i = $urandom; rs2_data_i = $urandom | 32'h8000_0000;
    for (int k = 1; k <= 10; k++) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    chk("flush_cycle_busy", 32'(busy_o), 32'd1);
    chk("flush_cycle_rv",   32'(result_valid_o), 32'd0);
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("post_flush_busy", 32'(busy_o), 32'd0);
    chk("post_flush_rv",   32'(result_valid_o), 32'd0);
    chk("post_flush_stall", 32'(stall_o), 32'd0);
    do_mul(32'd2, 32'd3, runs);
    chk("mul2x3_literal", result_o, 32'd6);
    idle_cycles(1);

    // Reset at RUN cycle 5, then 9 * 9 with full latency.
    valid_i = 1'b1; ALUCtrl_i = MUL;
    rs1_data_i = $urandom; rs2_data_i = 32'h8000_0009;
    for (int k = 1; k <= 5; k++) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_stall",  32'(stall_o), 32'd0);
    chk("midrst_busy",   32'(busy_o), 32'd0);
    chk("midrst_rv",     32'(result_valid_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    idle_cycles(1);
    do_mul(32'd9, 32'd9, runs);
    chk("mul9x9_literal", result_o, 32'd81);
    idle_cycles(1);

    // Back-to-back: second MUL issues the cycle after DONE.
    do_mul(32'd3, 32'd4, runs);
    do_mul(32'd5, 32'd5, runs);
    idle_cycles(1);

    // Early-termination corner operands (full latency in default build).
    do_mul(32'd12345, 32'd0, runs);
`ifdef MUL_EARLY_TERM_EN
    chk("rs2_zero_stall_cycles", 32'(runs + 1), 32'd2);
`else
    chk("rs2_zero_stall_cycles", 32'(runs + 1), 32'd33);
`endif
    idle_cycles(1);
    do_mul(32'd5, 32'd1, runs);
    chk("mul5x1_literal", result_o, 32'd5);
    idle_cycles(1);

    // Randomised operands, sometimes back-to-back.
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      do_mul(a, b, runs);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
